// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider state encoding and timing constants
package cpu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division iteration on unsigned magnitudes
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  // Shift the next dividend bit into the remainder and try subtracting the divisor
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider, quotient to lo and remainder to hi
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Sequencing: accept, iterate, apply signs, then pulse done for one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      IDLE: if (start) begin
        dz_d = divisor == '0;
        if (divisor == '0) begin
          state_d = DONE;
        end else begin
          quo_d     = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d     = divisor[WIDTH-1] ? -divisor : divisor;
          neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_d = dividend[WIDTH-1];
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = CALC;
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? FIX : CALC;
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table-driven checks of the signed divider
module tb_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_unit dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] l, input logic [31:0] h, input logic dz);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.lo = l; v.hi = h; v.dz = dz;
    v.lat = dz ? 0 : 33;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int n;
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({v.name, " busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check({v.name, " latency"}, n, v.lat);
    check({v.name, " lo"}, lo, v.lo);
    check({v.name, " hi"}, hi, v.hi);
    check({v.name, " div_zero"}, 32'(div_zero), 32'(v.dz));
    tick();
    check({v.name, " done_pulse"}, 32'(done), 32'd0);
    check({v.name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs.push_back(mk("p100_p7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0));
    vecs.push_back(mk("m100_p7",   32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0));
    vecs.push_back(mk("p100_m7",   32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0));
    vecs.push_back(mk("m100_m7",   32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0));
    vecs.push_back(mk("p100_p7b",  32'd100,        32'd7,          32'd14,         32'd2,          1'b0));
    vecs.push_back(mk("div0",      32'd5,          32'd0,          32'd14,         32'd2,          1'b1));
    vecs.push_back(mk("min_m1",    32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0));
    vecs.push_back(mk("p7_p100",   32'd7,          32'd100,        32'd0,          32'd7,          1'b0));
    vecs.push_back(mk("m1_p1",     32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0));
    vecs.push_back(mk("max_p2",    32'h7FFFFFFF,   32'd2,          32'h3FFFFFFF,   32'd1,          1'b0));
    vecs.push_back(mk("min_p1",    32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0));
    vecs.push_back(mk("m7_p2",     32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0));

    #2;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run(vecs[i]);
      if (vecs[i].dz) begin
        repeat (3) tick();
        check("div0_hold", 32'(div_zero), 32'd1);
        check("div0_hold_lo", lo, 32'd14);
        dividend = 32'd1;
        divisor  = 32'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("div0_clear", 32'(div_zero), 32'd0);
        while (busy && total < 100000) tick();
      end
    end

    begin : ignore_start
      int n;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 32'd50;
      divisor  = 32'd5;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 5;
      while (!done && n < 60) begin
        tick();
        n++;
      end
      check("ign latency", n, 33);
      check("ign lo", lo, 32'd14);
      check("ign hi", hi, 32'd2);
      tick();
      check("ign idle", 32'(busy), 32'd0);
    end

    begin : async_reset
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check("mid busy", 32'(busy), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      check("arst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      tick();
      tick();
      check("arst_hold", {29'd0, busy, done, div_zero}, 32'd0);
      reset = 1'b1;
      tick();
      run(mk("p9_p3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
